// File: rtl/shift_register_sipo_rx.sv
// shift_register_sipo_rx: MSB-first serial frame receiver with even-parity check and valid/ready word output
module shift_register_sipo_rx #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_en,
    input  logic             serial_in,
    input  logic             out_ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             parity_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] word_in;
    logic             shifting, last_bit, commit, load, perr_in;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Frame sequencing: start bit, WIDTH data bits, optional parity bit
    always_comb begin
        state_d = state_q;
        if (serial_en) begin
            unique case (state_q)
                IDLE:    state_d = serial_in ? DATA : IDLE;
                DATA:    state_d = (cnt_q == CW'(WIDTH - 1)) ? ((PARITY_EN != 0) ? PARITY : IDLE) : DATA;
                PARITY:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Shift/count datapath and output handshake; a commit into a stalled full slot is dropped as overrun
    always_comb begin
        shift_in = {shift_q[WIDTH-2:0], serial_in};
        shifting = serial_en && (state_q == DATA);
        last_bit = shifting && (cnt_q == CW'(WIDTH - 1));
        commit   = (last_bit && (PARITY_EN == 0)) || (serial_en && (state_q == PARITY));
        word_in  = (state_q == DATA) ? shift_in : shift_q;
        perr_in  = (state_q == PARITY) && ((^shift_q) ^ serial_in);
        load     = commit && (!valid_q || out_ready);
        shift_d  = shifting ? shift_in : shift_q;
        cnt_d    = !shifting ? cnt_q : (last_bit ? '0 : cnt_q + 1'b1);
        valid_d  = load || (valid_q && !out_ready);
        par_d    = load ? word_in : par_q;
        perr_d   = load ? perr_in : perr_q;
        ovr_d    = (commit && valid_q && !out_ready) || (ovr_q && !clear_err);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out = par_q;
    assign out_valid    = valid_q;
    assign parity_err   = perr_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_shift_register_sipo_rx.sv
// tb_shift_register_sipo_rx: table vectors, corner sequences and randomized checks against a frame-level model
module tb_shift_register_sipo_rx;
    localparam int WIDTH = 4;
    localparam int PE    = 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             serial_en = 1'b0;
    logic             serial_in = 1'b0;
    logic             out_ready = 1'b0;
    logic             clear_err = 1'b0;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid, parity_err, overrun;

    shift_register_sipo_rx #(.WIDTH(WIDTH), .PARITY_EN(PE)) dut (
        .clk(clk), .reset_n(reset_n), .serial_en(serial_en), .serial_in(serial_in),
        .out_ready(out_ready), .clear_err(clear_err), .parallel_out(parallel_out),
        .out_valid(out_valid), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit auto_chk = 0;

    // frame-level reference model
    bit   m_busy = 0;
    bit   m_bits[$];
    bit   m_valid = 0, m_perr = 0, m_ovr = 0;
    int   m_word = 0;

    typedef struct packed {
        logic       rn, en, sin, rdy, clr;
        logic       v;
        logic [3:0] w;
        logic       pe, ov;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit rn, en, sin, rdy, clr);
        bit commit = 0;
        int w = 0, ones = 0;
        bit set_ovr = 0;
        if (!rn) begin
            m_busy = 0; m_bits.delete(); m_valid = 0; m_perr = 0; m_ovr = 0; m_word = 0;
            return;
        end
        if (en) begin
            if (!m_busy) begin
                if (sin) begin m_busy = 1; m_bits.delete(); end
            end else begin
                m_bits.push_back(sin);
                if (m_bits.size() == WIDTH + PE) begin
                    for (int i = 0; i < WIDTH; i++) w = w * 2 + int'(m_bits[i]);
                    foreach (m_bits[i]) ones += int'(m_bits[i]);
                    commit = 1;
                    m_busy = 0;
                end
            end
        end
        if (commit && m_valid && !rdy) set_ovr = 1;
        else if (commit) begin
            m_word = w; m_perr = (PE != 0) && (ones % 2 == 1); m_valid = 1;
        end else if (m_valid && rdy) m_valid = 0;
        m_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    task automatic mcheck(input string tag);
        chk({tag, ".valid"}, int'(out_valid), int'(m_valid));
        chk({tag, ".overrun"}, int'(overrun), int'(m_ovr));
        if (m_valid) begin
            chk({tag, ".word"}, int'(parallel_out), m_word);
            chk({tag, ".perr"}, int'(parity_err), int'(m_perr));
        end
    endtask

    task automatic cyc(input bit rn, en, sin, rdy, clr);
        reset_n = rn; serial_en = en; serial_in = sin; out_ready = rdy; clear_err = clr;
        model_edge(rn, en, sin, rdy, clr);
        @(posedge clk);
        #1;
        if (auto_chk) mcheck("model");
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit bad_par, input bit rdy,
                              input bit last_rdy, input bit gap);
        logic pb;
        pb = (^w) ^ bad_par;
        cyc(1, 1, 1, rdy, 0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (gap) cyc(1, 0, 1, rdy, 0);
            cyc(1, 1, w[i], (i == 0 && PE == 0) ? last_rdy : rdy, 0);
        end
        if (PE != 0) begin
            if (gap) cyc(1, 0, 0, rdy, 0);
            cyc(1, 1, pb, last_rdy, 0);
        end
    endtask

    initial begin
        // reset rows, good frame 1011, then the same frame with a bad parity bit
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rn, tbl[i].en, tbl[i].sin, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d.overrun", i), int'(overrun), int'(tbl[i].ov));
            if (tbl[i].v || !tbl[i].rn) begin
                chk($sformatf("tbl%0d.word", i), int'(parallel_out), int'(tbl[i].w));
                chk($sformatf("tbl%0d.perr", i), int'(parity_err), int'(tbl[i].pe));
            end
        end
        auto_chk = 1;

        // overrun: A held, 5 dropped, then clear, then consume
        send_frame(4'hA, 0, 0, 0, 0);
        send_frame(4'h5, 0, 0, 0, 0);
        chk("ovr.word_kept", int'(parallel_out), 'hA);
        chk("ovr.flag", int'(overrun), 1);
        cyc(1, 0, 0, 0, 1);
        chk("ovr.cleared", int'(overrun), 0);
        chk("ovr.still_valid", int'(out_valid), 1);
        cyc(1, 0, 0, 1, 0);
        chk("ovr.consumed", int'(out_valid), 0);

        // overrun and clear on the same edge: set wins
        send_frame(4'h3, 0, 0, 0, 0);
        send_frame(4'hC, 0, 1, 1, 0);
        cyc(1, 1, 1, 0, 0);
        for (int i = 0; i < WIDTH; i++) cyc(1, 1, 1'(i % 2), 0, 0);
        cyc(1, 1, 1'b0, 0, 1);
        chk("setwins.overrun", int'(overrun), 1);
        cyc(1, 0, 0, 1, 1);

        // strobe gaps give the same word
        send_frame(4'h6, 0, 0, 0, 1);
        chk("gap.word", int'(parallel_out), 'h6);
        chk("gap.perr", int'(parity_err), 0);

        // commit on the consume edge
        send_frame(4'h9, 0, 0, 1, 0);
        chk("cc.valid", int'(out_valid), 1);
        chk("cc.word", int'(parallel_out), 'h9);
        chk("cc.overrun", int'(overrun), 0);
        cyc(1, 0, 0, 1, 0);

        // mid-frame reset discards partial bits
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        chk("mrst.valid", int'(out_valid), 0);
        send_frame(4'h9, 0, 1, 1, 0);
        chk("mrst.word", int'(parallel_out), 'h9);
        chk("mrst.valid1", int'(out_valid), 1);
        cyc(1, 0, 0, 1, 0);
        chk("mrst.one_word", int'(out_valid), 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_register_sipo_rx.md
# shift_register_sipo_rx

Serial-in, parallel-out frame receiver that consumes the MSB-first bit stream produced by the team's PISO shift register and rebuilds parallel words. It detects a start bit, collects WIDTH data bits, optionally checks an even-parity bit, and presents each word on a valid/ready output port. It sits directly downstream of the serializer, across a single-clock serial link gated by a bit strobe.

## Interface
- WIDTH, 4: data bits per frame; legal range 2..32.
- PARITY_EN, 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit.
- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- serial_en  in  1  bit strobe; serial_in is sampled only on edges where serial_en=1.
- serial_in  in  1  serial data; MSB first.
- out_ready  in  1  downstream accepts the word on an edge where out_valid=1 and out_ready=1.
- clear_err  in  1  single-cycle pulse that clears the sticky overrun flag.
- parallel_out  out  WIDTH  received word; held stable while out_valid=1.
- out_valid  out  1  parallel_out holds an unconsumed word.
- parity_err  out  1  parity result for the word currently on parallel_out; 0 when PARITY_EN=0.
- overrun  out  1  sticky flag; a completed frame was dropped.

## Operation
- Reset is synchronous and active-low: reset_n=0 at a clk edge forces state IDLE, the shift register to 0, the bit counter to 0, parallel_out to 0, and out_valid, parity_err and overrun to 0. Reset overrides every other input, including a frame in progress. Any partial frame is discarded.
- The frame format is 1 start bit (value 1), then WIDTH data bits MSB first, then 1 parity bit if PARITY_EN=1. The line idles at 0.
- The FSM has three states: IDLE, DATA, PARITY. Edges with serial_en=0 cause no state, counter or shift change.
  - IDLE: on serial_en=1 and serial_in=1, go to DATA with counter=0. A 0 bit stays in IDLE.
  - DATA: on serial_en=1, shift left with serial_in entering the LSB, and increment the counter. On the WIDTH-th bit, go to PARITY if PARITY_EN=1; otherwise commit and go to IDLE.
  - PARITY: on serial_en=1, compute parity_err = (XOR of the data bits) XOR serial_in, commit, and go to IDLE.
- Commit loads parallel_out and parity_err and sets out_valid=1, subject to the output rules below.
- Output handshake:
  - A word is consumed on an edge with out_valid=1 and out_ready=1. out_valid then clears unless a commit occurs on the same edge.
  - Commit with out_valid=0: load the word.
  - Commit with out_valid=1 and out_ready=1 on the same edge: the old word is consumed, the new word is loaded, out_valid stays 1, and overrun is not set.
  - Commit with out_valid=1 and out_ready=0: drop the new word, keep the old word and its parity_err unchanged, and set overrun=1.
- overrun clears only on clear_err=1 or reset. If an overrun and clear_err occur on the same edge, overrun ends at 1 (set wins).
- Width rules: the bit counter is $clog2(WIDTH+1) bits. It never wraps within a frame and returns to 0 on leaving DATA.
- A start bit received on the same strobe that completes a frame is not possible, because one strobe carries one bit. The next frame's start bit needs a later strobe while in IDLE.

## Timing
- Minimum frame length is 1+WIDTH+PARITY_EN strobes. Back-to-back frames are supported: the start bit may arrive on the very next strobe after commit.
- Latency: out_valid, parallel_out and parity_err update on the same edge that samples the final bit (the last data bit, or the parity bit). They are visible in the following cycle.
- overrun rises on the dropping commit edge.
- All outputs are registered, and no output depends combinationally on an input.
- Throughput: with serial_en tied to 1 and PARITY_EN=1, WIDTH=4, there is one word per 6 cycles.

## Test plan
- Reset state: reset_n=0 for 2 cycles with serial_en=1 and serial_in=1 -> parallel_out=0, out_valid=0, parity_err=0, overrun=0; the FSM stays IDLE.
- Basic frame: WIDTH=4, PARITY_EN=1, serial_en=1, out_ready=1, bits 1,1,0,1,1,1 -> one cycle after the 6th edge parallel_out=4'b1011, out_valid=1, parity_err=0; out_valid drops after the next edge.
- Parity error: same frame with parity bit 0 -> parallel_out=4'b1011, parity_err=1.
- Overrun: out_ready=0, two frames 4'hA then 4'h5 (correct parity) -> parallel_out stays 4'hA and overrun=1. Then clear_err=1 -> overrun=0. Then out_ready=1 -> 4'hA is consumed.
- Strobe gaps and simultaneous events: serial_en toggles 1/0 through a frame of 4'h6 -> result is identical to the ungapped case. A commit on the same edge as consume -> out_valid stays 1 with the new word and overrun stays 0.
- Mid-frame reset: reset_n=0 after 2 data bits, then a full frame of 4'h9 -> only 4'h9 is received; no stale bits appear.
